// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two core-side memory masters, the arbiter and the SRAM port.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            m0_req,   m1_req;
   logic            m0_we,    m1_we;
   logic [DW/8-1:0] m0_wmask, m1_wmask;
   logic [AW-1:0]   m0_addr,  m1_addr;
   logic [DW-1:0]   m0_wdata, m1_wdata;
   logic [DW-1:0]   m0_rdata, m1_rdata;
   logic            m0_ack,   m1_ack;
   logic            m0_err,   m1_err;
   logic            s_sel;
   logic            s_we;
   logic [DW/8-1:0] s_byte_en;
   logic [AW-1:0]   s_addr;
   logic [DW-1:0]   s_din;
   logic [DW-1:0]   s_dout;
   logic            s_ack;

   // Arbiter view: takes master requests and slave responses, drives everything else.
   modport slave (
      input  m0_req, m1_req, m0_we, m1_we, m0_wmask, m1_wmask,
      input  m0_addr, m1_addr, m0_wdata, m1_wdata,
      output m0_rdata, m1_rdata, m0_ack, m1_ack, m0_err, m1_err,
      output s_sel, s_we, s_byte_en, s_addr, s_din,
      input  s_dout, s_ack
   );

   // Environment view: the two core masters together with the SRAM.
   modport master (
      output m0_req, m1_req, m0_we, m1_we, m0_wmask, m1_wmask,
      output m0_addr, m1_addr, m0_wdata, m1_wdata,
      input  m0_rdata, m1_rdata, m0_ack, m1_ack, m0_err, m1_err,
      input  s_sel, s_we, s_byte_en, s_addr, s_din,
      output s_dout, s_ack
   );
endinterface

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter in front of a single-ported SRAM. One access
// in flight at a time; a watchdog turns a missing slave ack into an error pulse.
module mem_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic         clk,
   input  logic         rst,
   mem_arbiter_if.slave bus
);

   localparam int BW = DW / 8;
   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nx;
   logic          gnt, gnt_nx;
   logic          last_gnt, last_gnt_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          win;
   logic          tmo_hit;
   logic          active;
   logic          sel_we;
   logic [BW-1:0] sel_wmask;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;

   // Watchdog expires on the last permitted BUSY cycle; a TIMEOUT of 0 disables it.
   assign tmo_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);

   // Outputs are held quiet while rst is high so an abandoned access never acks.
   assign active = (state == BUSY) && !rst;

   // State, grant and wait-counter registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         gnt      <= 1'b0;
         last_gnt <= 1'b1;
         cnt      <= '0;
      end else begin
         state    <= state_nx;
         gnt      <= gnt_nx;
         last_gnt <= last_gnt_nx;
         cnt      <= cnt_nx;
      end
   end

   // Next-state: round-robin arbitration in IDLE, completion/timeout exit in BUSY.
   always_comb begin
      state_nx    = state;
      gnt_nx      = gnt;
      last_gnt_nx = last_gnt;
      cnt_nx      = cnt;
      win         = 1'b0;
      case (state)
         IDLE: begin
            if (bus.m0_req && bus.m1_req) win = ~last_gnt;
            else                          win = bus.m1_req;
            if (bus.m0_req || bus.m1_req) begin
               state_nx    = BUSY;
               gnt_nx      = win;
               last_gnt_nx = win;
               cnt_nx      = '0;
            end
         end
         BUSY: begin
            if (bus.s_ack || tmo_hit) state_nx = IDLE;
            else if (cnt != '1)       cnt_nx   = cnt + CW'(1);
         end
         default: state_nx = IDLE;
      endcase
   end

   // Select the granted master's request attributes.
   always_comb begin
      if (gnt) begin
         sel_we    = bus.m1_we;
         sel_wmask = bus.m1_wmask;
         sel_addr  = bus.m1_addr;
         sel_wdata = bus.m1_wdata;
      end else begin
         sel_we    = bus.m0_we;
         sel_wmask = bus.m0_wmask;
         sel_addr  = bus.m0_addr;
         sel_wdata = bus.m0_wdata;
      end
   end

   // Drive the slave port and route completion/error back to the granted master.
   always_comb begin
      bus.s_sel     = 1'b0;
      bus.s_we      = 1'b0;
      bus.s_byte_en = '0;
      bus.s_addr    = '0;
      bus.s_din     = '0;
      bus.m0_ack    = 1'b0;
      bus.m1_ack    = 1'b0;
      bus.m0_err    = 1'b0;
      bus.m1_err    = 1'b0;
      bus.m0_rdata  = '0;
      bus.m1_rdata  = '0;
      if (active) begin
         bus.s_sel     = 1'b1;
         bus.s_we      = sel_we;
         bus.s_byte_en = sel_we ? sel_wmask : '1;
         bus.s_addr    = sel_addr;
         bus.s_din     = sel_wdata;
         if (gnt) begin
            bus.m1_ack   = bus.s_ack;
            bus.m1_err   = !bus.s_ack && tmo_hit;
            bus.m1_rdata = bus.s_ack ? bus.s_dout : '0;
         end else begin
            bus.m0_ack   = bus.s_ack;
            bus.m0_err   = !bus.s_ack && tmo_hit;
            bus.m0_rdata = bus.s_ack ? bus.s_dout : '0;
         end
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each
// grant and its completion cycle; a monitor compares DUT responses against it.
module tb_mem_arbiter;

   localparam int TMO   = 4;
   localparam int NEVER = 100;

   typedef struct {
      logic        we;
      logic [3:0]  wmask;
      logic [31:0] addr;
      logic [31:0] wdata;
   } cmd_t;

   typedef struct {
      int          start;
      int          fin;
      int          m;
      bit          is_err;
      logic [31:0] rdata;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] din;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = '0;
   logic [1:0]  we  = '0;
   logic [3:0]  wmask [2];
   logic [31:0] addr  [2];
   logic [31:0] wdata [2];
   logic        s_ack  = 1'b0;
   logic [31:0] s_dout = '0;

   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;
   bit   auto_on = 1'b0;
   cmd_t cmd_q0 [$];
   cmd_t cmd_q1 [$];
   int   lat_q [$];
   logic [31:0] dat_q [$];
   exp_t exp_q [$];
   exp_t cur;
   bit   cur_valid = 1'b0;
   int   last = 1;
   int   resp_cnt [2];
   int   seen_cnt [2];

   mem_arbiter_if #(.AW(32), .DW(32)) bus ();

   mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.m0_req   = req[0];
   assign bus.m1_req   = req[1];
   assign bus.m0_we    = we[0];
   assign bus.m1_we    = we[1];
   assign bus.m0_wmask = wmask[0];
   assign bus.m1_wmask = wmask[1];
   assign bus.m0_addr  = addr[0];
   assign bus.m1_addr  = addr[1];
   assign bus.m0_wdata = wdata[0];
   assign bus.m1_wdata = wdata[1];
   assign bus.s_ack    = s_ack;
   assign bus.s_dout   = s_dout;

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic cmd_t mk_cmd(input logic w, input logic [3:0] m,
                                   input logic [31:0] a, input logic [31:0] d);
      cmd_t c;
      c.we = w; c.wmask = m; c.addr = a; c.wdata = d;
      return c;
   endfunction

   function automatic cmd_t rand_cmd();
      return mk_cmd(1'($urandom_range(0, 1)), 4'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
   endfunction

   task automatic issue(input int i, input cmd_t c);
      we[i]    = c.we;
      wmask[i] = c.wmask;
      addr[i]  = c.addr;
      wdata[i] = c.wdata;
      req[i]   = 1'b1;
   endtask

   // Reference model + stimulus: predicts grants at each edge, then drives masters and slave.
   initial begin : driver
      int          w;
      int          lat;
      logic [31:0] d;
      for (int i = 0; i < 2; i++) begin
         wmask[i] = '0; addr[i] = '0; wdata[i] = '0;
         resp_cnt[i] = 0; seen_cnt[i] = 0;
      end
      forever begin
         @(posedge clk);
         cyc++;
         if (rst) begin
            cur_valid = 1'b0;
            last      = 1;
            exp_q.delete();
         end else if ((!cur_valid || cur.fin < cyc - 1) && req != 2'b00) begin
            if (req == 2'b11) w = 1 - last;
            else              w = req[1] ? 1 : 0;
            last = w;
            lat  = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(1, 6));
            d    = (dat_q.size() != 0) ? dat_q.pop_front() : $urandom;
            cur.start  = cyc;
            cur.m      = w;
            cur.is_err = (TMO != 0) && (lat > TMO);
            cur.fin    = cyc + (cur.is_err ? TMO : lat) - 1;
            cur.rdata  = cur.is_err ? '0 : d;
            cur.we     = we[w];
            cur.be     = we[w] ? wmask[w] : 4'hF;
            cur.addr   = addr[w];
            cur.din    = wdata[w];
            cur_valid  = 1'b1;
            exp_q.push_back(cur);
         end
         #1;
         for (int i = 0; i < 2; i++) begin
            if (resp_cnt[i] > seen_cnt[i]) begin
               seen_cnt[i]++;
               req[i] = 1'b0;
            end
            if (!req[i]) begin
               if (i == 0 && cmd_q0.size() != 0)      issue(0, cmd_q0.pop_front());
               else if (i == 1 && cmd_q1.size() != 0) issue(1, cmd_q1.pop_front());
               else if (auto_on && $urandom_range(0, 2) == 0) issue(i, rand_cmd());
            end
         end
         if (cur_valid && !rst && cyc >= cur.start && cyc <= cur.fin) begin
            s_ack  = (cyc == cur.fin) && !cur.is_err;
            s_dout = s_ack ? cur.rdata : $urandom;
         end else begin
            s_ack  = ($urandom_range(0, 3) == 0);
            s_dout = $urandom;
         end
      end
   end

   // Monitor: pops the scoreboard on every ack/err and checks the slave bus each cycle.
   initial begin : monitor
      logic [1:0]  ack;
      logic [1:0]  err;
      logic [31:0] rd [2];
      bit          busy;
      exp_t        e;
      forever begin
         @(negedge clk);
         ack   = {bus.m1_ack, bus.m0_ack};
         err   = {bus.m1_err, bus.m0_err};
         rd[0] = bus.m0_rdata;
         rd[1] = bus.m1_rdata;
         if (rst) begin
            chk("rst_ctl",  {ack, err, bus.s_sel, bus.s_we, bus.s_byte_en}, '0);
            chk("rst_data", {rd[0], rd[1]}, '0);
            chk("rst_bus",  {bus.s_addr, bus.s_din}, '0);
         end else begin
            busy = cur_valid && cyc >= cur.start && cyc <= cur.fin;
            chk("s_sel", bus.s_sel, busy);
            if (busy) begin
               chk("s_we",      bus.s_we,      cur.we);
               chk("s_byte_en", bus.s_byte_en, cur.be);
               chk("s_addr",    bus.s_addr,    cur.addr);
               chk("s_din",     bus.s_din,     cur.din);
            end else begin
               chk("idle_ctl",  {bus.s_we, bus.s_byte_en}, '0);
               chk("idle_bus",  {bus.s_addr, bus.s_din}, '0);
            end
            for (int i = 0; i < 2; i++) begin
               if (ack[i] || err[i]) begin
                  resp_cnt[i]++;
                  if (exp_q.size() == 0) begin
                     fail("unexpected_resp");
                  end else begin
                     e = exp_q.pop_front();
                     chk("resp_master", i, e.m);
                     chk("resp_cycle",  cyc, e.fin);
                     chk("resp_err",    err[i], e.is_err);
                     chk("resp_ack",    ack[i], !e.is_err);
                     if (ack[i]) chk("rdata", rd[i], e.rdata);
                  end
               end else if (!busy || cur.m != i) begin
                  chk("rdata_zero", rd[i], '0);
               end
            end
            if (exp_q.size() != 0 && exp_q[0].fin < cyc) begin
               fail("missing_resp");
               void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic wait_quiet(input int limit);
      int n = 0;
      while ((exp_q.size() != 0 || cmd_q0.size() != 0 || cmd_q1.size() != 0 || req != 2'b00)
             && n < limit) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0 || cmd_q0.size() != 0 || cmd_q1.size() != 0 || req != 2'b00)
         fail("quiet_timeout");
      @(posedge clk);
      #2;
   endtask

   initial begin : main
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      // Contention straight out of reset: zero-wait slave, m0 must win first.
      for (int k = 0; k < 4; k++) begin
         cmd_q0.push_back(rand_cmd());
         cmd_q1.push_back(rand_cmd());
      end
      for (int k = 0; k < 8; k++) lat_q.push_back(1);
      wait_quiet(60);

      // Single read, zero-wait slave.
      cmd_q0.push_back(mk_cmd(1'b0, 4'h0, 32'h0000_0100, 32'h0));
      lat_q.push_back(1);
      dat_q.push_back(32'hDEAD_BEEF);
      wait_quiet(20);

      // Masked write from m1, slave acks on the third BUSY cycle.
      cmd_q1.push_back(mk_cmd(1'b1, 4'h3, 32'h0000_0204, 32'h0000_ABCD));
      lat_q.push_back(3);
      dat_q.push_back(32'h0);
      wait_quiet(20);

      // Timeout on m0 with m1 arriving while it is stuck.
      cmd_q0.push_back(mk_cmd(1'b0, 4'h0, 32'h0000_0300, 32'h0));
      lat_q.push_back(NEVER);
      lat_q.push_back(1);
      @(posedge clk);
      @(posedge clk);
      #2;
      cmd_q1.push_back(rand_cmd());
      wait_quiet(30);

      // Ack on the same cycle the watchdog would expire.
      cmd_q0.push_back(mk_cmd(1'b0, 4'h0, 32'h0000_0400, 32'h0));
      lat_q.push_back(TMO);
      wait_quiet(20);

      // Reset in the middle of an m1 access, then contention after release.
      cmd_q1.push_back(rand_cmd());
      lat_q.push_back(NEVER);
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      cmd_q0.push_back(rand_cmd());
      lat_q.push_back(2);
      lat_q.push_back(2);
      @(posedge clk);
      #2 rst = 1'b0;
      wait_quiet(40);

      // Random traffic from both masters with random slave latency.
      auto_on = 1'b1;
      repeat (400) @(posedge clk);
      #2 auto_on = 1'b0;
      wait_quiet(60);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

endmodule
